// File: rtl/spi_response_transmitter_if.sv
// Host-side push bus for spi_response_transmitter.
//  tx_data   byte to queue
//  tx_valid  push request
//  tx_ready  FIFO not full; push accepted when tx_valid && tx_ready
//  flush     1-cycle pulse, empties the FIFO
interface spi_response_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       flush;

  modport master (output tx_data, tx_valid, flush, input tx_ready);
  modport slave  (input tx_data, tx_valid, flush, output tx_ready);
endinterface

// File: rtl/spi_response_transmitter.sv
// Slave-side SPI MISO transmitter (mode 0, MSB first).
// Response bytes are queued from the clock domain into a FIFO. cs/sck are
// synchronised and edge-detected in the clock domain, so no logic runs on sck.
// The byte being shifted is peeked from the FIFO head and popped only after its
// 8th sck fall, so a byte cut short by cs release is resent on the next frame.
// Ports:
//  clock, reset_n      system clock / async active-low reset
//  cs, sck             SPI chip select (active low) and serial clock, async
//  miso, miso_oe       serial data out and pad drive enable
//  bus                 push bus (tx_data/tx_valid/tx_ready/flush)
//  fifo_level          bytes queued, including the byte in flight
//  byte_sent           pulse: a FIFO byte fully shifted out
//  underrun            pulse: IDLE_BYTE loaded because the FIFO was empty
//  tx_abort            pulse: cs released mid-byte
module spi_response_transmitter #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cs,
  input  logic                          sck,
  output logic                          miso,
  output logic                          miso_oe,
  spi_response_transmitter_if.slave     bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          byte_sent,
  output logic                          underrun,
  output logic                          tx_abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  // ---------------- synchronisers / edge detect ----------------
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_d     <= cs_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_fall = sck_d & ~sck_s;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level;
  logic          full, push, pop;

  assign full         = (level == LW'(FIFO_DEPTH));
  assign bus.tx_ready = ~full;
  assign fifo_level   = level;
  assign rd_next      = rd_ptr + 1'b1;
  // flush wins over a simultaneous push
  assign push         = bus.tx_valid & ~full & ~bus.flush;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- control FSM ----------------
  state_t     state_q, state_d;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       from_fifo;   // byte in the shifter is the (unpopped) FIFO head
  logic       load, shift_en, abort, hit;
  logic [7:0] load_byte;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    pop      = 1'b0;
    abort    = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
      abort   = (bit_cnt != 3'd0);
    end else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = LOAD;
        LOAD:  begin
          load    = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: if (sck_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            // a flushed byte still finishes shifting but is never popped
            pop  = from_fifo & ~bus.flush;
            load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // next byte: entry after the one being popped, else current head
    if (bus.flush)  hit = 1'b0;
    else if (pop)   hit = (level >= LW'(2));
    else            hit = (level != '0);
    load_byte = pop ? mem[rd_next] : mem[rd_ptr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift     <= IDLE_BYTE;
      bit_cnt   <= '0;
      from_fifo <= 1'b0;
      miso_oe   <= 1'b0;
      byte_sent <= 1'b0;
      underrun  <= 1'b0;
      tx_abort  <= 1'b0;
    end else begin
      byte_sent <= pop;
      underrun  <= load & ~hit;
      tx_abort  <= abort;

      if (load)          shift <= hit ? load_byte : IDLE_BYTE;
      else if (shift_en) shift <= {shift[6:0], 1'b0};

      if (cs_rise)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (cs_rise)       miso_oe <= 1'b0;
      else if (load)     miso_oe <= 1'b1;

      if (cs_rise || bus.flush) from_fifo <= 1'b0;
      else if (load)            from_fifo <= hit;
    end
  end

  assign miso = shift[7];

endmodule
